bayer_mosaic_stream: RTL and testbench

// - Raster RGB stream -> RGGB Bayer raw stream. Inverse of the 3x3 demosaic path.
// - Produces raw frames (one 8-bit sample per pixel) to build and regress demosaic test images.
// - Sits between an RGB pixel source and the raw image writer / demosaic input.

---
 rtl/bayer_mosaic_stream.sv | 141 ++++++++++++++
 tb/tb_bayer_mosaic_stream.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bayer_mosaic_stream.sv
// Converts a raster RGB pixel stream into an RGGB Bayer raw stream, one sample per pixel.
// A single output register backed by a one-entry skid buffer keeps full throughput under backpressure.
module bayer_mosaic_stream #(
  parameter int WIDTH  = 40,
  parameter int HEIGHT = 30,
  parameter int XW     = 6,
  parameter int YW     = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_red,
  input  logic [7:0]    in_green,
  input  logic [7:0]    in_blue,
  input  logic          in_sof,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_raw,
  output logic [1:0]    out_color,
  output logic [XW-1:0] out_x,
  output logic [YW-1:0] out_y,
  output logic          out_sof,
  output logic          out_eol,
  output logic          out_eof,
  output logic          sync_error,
  output logic [15:0]   frame_count
);

  localparam int SW = 8 + 2 + XW + YW + 3;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    ACTIVE   = 1'b1
  } state_t;

  state_t          state;
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic            skid_full;
  logic [SW-1:0]   skid_data;
  logic [SW-1:0]   out_data;

  logic            accept;
  logic            emit;
  logic            out_load;
  logic            restart;
  logic [XW-1:0]   pos_x;
  logic [YW-1:0]   pos_y;
  logic            last_col;
  logic            last_row;
  logic [1:0]      color;
  logic [7:0]      raw;
  logic [SW-1:0]   sample;

  assign in_ready = !skid_full && !reset;
  assign {out_raw, out_color, out_x, out_y, out_sof, out_eol, out_eof} = out_data;

  // Position, site and sample for the pixel offered this cycle
  always_comb begin
    accept   = in_valid && in_ready;
    emit     = accept && ((state == ACTIVE) || in_sof);
    out_load = !out_valid || out_ready;
    restart  = (state == ACTIVE) && in_sof && ((x != '0) || (y != '0));
    if (in_sof) begin
      pos_x = '0;
      pos_y = '0;
    end else begin
      pos_x = x;
      pos_y = y;
    end
    last_col = (pos_x == XW'(WIDTH - 1));
    last_row = (pos_y == YW'(HEIGHT - 1));
    case ({pos_x[0], pos_y[0]})
      2'b00:   color = 2'd0;
      2'b11:   color = 2'd1;
      2'b10:   color = 2'd2;
      default: color = 2'd3;
    endcase
    case (color)
      2'd0:    raw = in_red;
      2'd1:    raw = in_blue;
      default: raw = in_green;
    endcase
    sample = {raw, color, pos_x, pos_y, (pos_x == '0) && (pos_y == '0), last_col, last_col && last_row};
  end

  // Frame FSM, raster counters and status; counters move only on input handshakes
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= WAIT_SOF;
      x           <= '0;
      y           <= '0;
      sync_error  <= 1'b0;
      frame_count <= 16'd0;
    end else if (emit) begin
      if (restart) begin
        sync_error <= 1'b1;
      end
      if (last_col && last_row) begin
        x           <= '0;
        y           <= '0;
        state       <= WAIT_SOF;
        frame_count <= frame_count + 16'd1;
      end else if (last_col) begin
        x     <= '0;
        y     <= pos_y + YW'(1);
        state <= ACTIVE;
      end else begin
        x     <= pos_x + XW'(1);
        y     <= pos_y;
        state <= ACTIVE;
      end
    end
  end

  // Output register and skid; the skid always drains before new input is taken
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      skid_full <= 1'b0;
      skid_data <= '0;
    end else if (out_load) begin
      if (skid_full) begin
        out_data  <= skid_data;
        out_valid <= 1'b1;
        skid_full <= 1'b0;
      end else if (emit) begin
        out_data  <= sample;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (emit) begin
      skid_data <= sample;
      skid_full <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bayer_mosaic_stream.sv
// Self-checking bench for bayer_mosaic_stream: scoreboard against a behavioural model,
// a table of sample-site vectors from a ramp frame, and hand-built stall/sync/reset sequences.
module tb_bayer_mosaic_stream;
  localparam int W = 40;
  localparam int H = 30;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_ready, in_sof;
  logic [7:0] in_red, in_green, in_blue;
  logic       out_valid, out_ready;
  logic [7:0] out_raw;
  logic [1:0] out_color;
  logic [5:0] out_x;
  logic [4:0] out_y;
  logic       out_sof, out_eol, out_eof, sync_error;
  logic [15:0] frame_count;

  always #5 clk = ~clk;

  bayer_mosaic_stream #(.WIDTH(W), .HEIGHT(H), .XW(6), .YW(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_red(in_red), .in_green(in_green), .in_blue(in_blue), .in_sof(in_sof),
    .out_valid(out_valid), .out_ready(out_ready), .out_raw(out_raw), .out_color(out_color),
    .out_x(out_x), .out_y(out_y), .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
    .sync_error(sync_error), .frame_count(frame_count)
  );

  typedef struct {
    logic [7:0] raw;
    logic [1:0] color;
    int         x;
    int         y;
    logic       sof, eol, eof;
  } samp_t;

  typedef struct {
    logic [7:0] r, g, b;
    logic       sof;
  } pix_t;

  typedef struct {
    int         x;
    int         y;
    logic [7:0] raw;
    logic [1:0] color;
  } vec_t;

  samp_t exp_q[$];
  pix_t  src_q[$];
  int    checks = 0;
  int    passed = 0;

  bit    m_active;
  int    m_x, m_y, m_fc;

  bit         capture = 0;
  logic [7:0] cap_raw [0:H-1][0:W-1];
  logic [1:0] cap_col [0:H-1][0:W-1];
  int         n_out, n_eof;
  int         first_x, first_y;
  logic       first_sof;

  function automatic void check(string name, int act, int req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endfunction

  // Reference behaviour: decides what an accepted pixel should become
  function automatic void model_accept(pix_t p);
    samp_t s;
    int px, py;
    if (!m_active && !p.sof) return;
    px = p.sof ? 0 : m_x;
    py = p.sof ? 0 : m_y;
    s.x = px;
    s.y = py;
    if (px % 2 == 0 && py % 2 == 0) begin s.color = 2'd0; s.raw = p.r; end
    else if (px % 2 == 1 && py % 2 == 1) begin s.color = 2'd1; s.raw = p.b; end
    else if (px % 2 == 1) begin s.color = 2'd2; s.raw = p.g; end
    else begin s.color = 2'd3; s.raw = p.g; end
    s.sof = (px == 0 && py == 0);
    s.eol = (px == W - 1);
    s.eof = (px == W - 1 && py == H - 1);
    exp_q.push_back(s);
    if (s.eof) begin
      m_active = 0; m_x = 0; m_y = 0; m_fc = (m_fc + 1) % 65536;
    end else begin
      m_active = 1;
      m_x = (px == W - 1) ? 0 : px + 1;
      m_y = (px == W - 1) ? py + 1 : py;
    end
  endfunction

  function automatic void compare_out();
    samp_t e;
    bit ok;
    checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected_out: got sample at (%0d,%0d), expected none", out_x, out_y);
      return;
    end
    e = exp_q.pop_front();
    ok = (out_raw == e.raw) && (out_color == e.color) && (int'(out_x) == e.x) && (int'(out_y) == e.y)
         && (out_sof == e.sof) && (out_eol == e.eol) && (out_eof == e.eof);
    if (ok) passed++;
    else $display("FAIL sample: got raw=%0d col=%0d (%0d,%0d) sof/eol/eof=%b%b%b, expected raw=%0d col=%0d (%0d,%0d) sof/eol/eof=%b%b%b",
                  out_raw, out_color, out_x, out_y, out_sof, out_eol, out_eof,
                  e.raw, e.color, e.x, e.y, e.sof, e.eol, e.eof);
    if (n_out == 0) begin first_x = out_x; first_y = out_y; first_sof = out_sof; end
    n_out++;
    if (out_eof) n_eof++;
    if (capture) begin cap_raw[out_y][out_x] = out_raw; cap_col[out_y][out_x] = out_color; end
  endfunction

  task automatic push_ramp(int k0, int n, bit first_sof, int off);
    pix_t p;
    for (int k = k0; k < k0 + n; k++) begin
      p.r = 8'((k % W) + off);
      p.g = 8'(((k / W) % H) + off);
      p.b = 8'(((k % W) ^ ((k / W) % H)) + off);
      p.sof = first_sof && (k == k0);
      src_q.push_back(p);
    end
  endtask

  task automatic push_pix(logic [7:0] r, logic [7:0] g, logic [7:0] b, logic sof);
    pix_t p;
    p.r = r; p.g = g; p.b = b; p.sof = sof;
    src_q.push_back(p);
  endtask

  // Runs cycles at negedges until all pixels are consumed and all expected samples seen
  task automatic drain(int vpct, int rpct, int stall_at, int budget, output int cycles, output bit saw_low);
    bit acc;
    bit stall;
    cycles = 0;
    saw_low = 0;
    while ((src_q.size() > 0 || in_valid || exp_q.size() > 0) && cycles < budget) begin
      if (!in_valid && src_q.size() > 0 && $urandom_range(0, 99) < vpct) begin
        in_valid = 1'b1;
        in_red = src_q[0].r; in_green = src_q[0].g; in_blue = src_q[0].b; in_sof = src_q[0].sof;
      end
      stall = (cycles >= stall_at) && (cycles < stall_at + 5);
      out_ready = stall ? 1'b0 : ($urandom_range(0, 99) < rpct);
      if (stall && !in_ready) saw_low = 1;
      acc = in_valid && in_ready;
      if (acc) model_accept(src_q.pop_front());
      if (out_valid && out_ready) compare_out();
      @(negedge clk);
      cycles++;
      if (acc) in_valid = 1'b0;
    end
    check("drain_within_budget", int'(cycles < budget), 1);
  endtask

  task automatic reset_dut();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_sof = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("in_ready_during_reset", in_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    exp_q.delete(); src_q.delete();
    m_active = 0; m_x = 0; m_y = 0; m_fc = 0;
    n_out = 0; n_eof = 0;
  endtask

  vec_t vecs[10];
  int   cyc;
  bit   low;

  initial begin
    in_red = 8'd0; in_green = 8'd0; in_blue = 8'd0;
    vecs[0] = '{0, 0, 8'd0, 2'd0};   vecs[1] = '{1, 0, 8'd0, 2'd2};
    vecs[2] = '{1, 1, 8'd0, 2'd1};   vecs[3] = '{0, 1, 8'd1, 2'd3};
    vecs[4] = '{38, 6, 8'd38, 2'd0}; vecs[5] = '{5, 7, 8'd2, 2'd1};
    vecs[6] = '{3, 8, 8'd8, 2'd2};   vecs[7] = '{10, 13, 8'd13, 2'd3};
    vecs[8] = '{39, 29, 8'd58, 2'd1}; vecs[9] = '{22, 17, 8'd17, 2'd3};

    reset_dut();
    check("reset_out_valid", out_valid, 0);
    check("reset_frame_count", frame_count, 0);
    check("reset_sync_error", sync_error, 0);
    check("reset_out_xy", {out_x, out_y}, 0);
    check("in_ready_after_reset", in_ready, 1);

    // Full ramp frame at full rate
    push_ramp(0, W * H, 1, 0);
    capture = 1;
    drain(100, 100, -100, 5000, cyc, low);
    capture = 0;
    check("ramp_cycles", cyc, W * H + 1);
    check("ramp_frame_count", frame_count, 1);
    check("ramp_eof_count", n_eof, 1);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("vec%0d_raw", i), cap_raw[vecs[i].y][vecs[i].x], vecs[i].raw);
      check($sformatf("vec%0d_color", i), cap_col[vecs[i].y][vecs[i].x], vecs[i].color);
    end

    // Pixels before the first sof are dropped
    reset_dut();
    push_pix(8'h11, 8'h22, 8'h33, 1'b0);
    push_pix(8'h44, 8'h55, 8'h66, 1'b0);
    push_pix(8'h77, 8'h88, 8'h99, 1'b0);
    drain(100, 100, -100, 100, cyc, low);
    check("presof_no_output", n_out, 0);
    check("presof_out_valid", out_valid, 0);
    push_pix(8'hC1, 8'hC2, 8'hC3, 1'b1);
    push_ramp(1, 5, 0, 0);
    drain(100, 100, -100, 100, cyc, low);
    check("presof_first_sof", first_sof, 1);
    check("presof_first_xy", first_x * 100 + first_y, 0);

    // Output stalled 5 cycles mid-line
    reset_dut();
    push_ramp(0, 2 * W, 1, 3);
    drain(100, 100, 20, 500, cyc, low);
    check("stall_in_ready_dropped", low, 1);
    check("stall_count", n_out, 2 * W);

    // Unexpected sof at (17,4), then a complete frame
    reset_dut();
    push_ramp(0, 4 * W + 17, 1, 0);
    push_pix(8'hA5, 8'h5A, 8'h3C, 1'b1);
    push_ramp(1, W * H - 1, 0, 0);
    drain(100, 100, -100, 5000, cyc, low);
    check("sync_error_set", sync_error, 1);
    check("sync_frame_count", frame_count, 1);

    // Random handshakes over three frames
    reset_dut();
    for (int f = 0; f < 3; f++) push_ramp(0, W * H, 1, 7 * f);
    drain(50, 50, -100, 30000, cyc, low);
    check("random_frame_count", frame_count, 3);
    check("random_sync_error", sync_error, 0);

    // Reset at (20,10) with a loaded pipeline, then a fresh frame
    reset_dut();
    push_ramp(0, 10 * W + 20, 1, 0);
    drain(100, 100, -100, 1000, cyc, low);
    in_valid = 1'b1; in_sof = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset_dut();
    check("midreset_out_valid", out_valid, 0);
    check("midreset_frame_count", frame_count, 0);
    push_ramp(20, 5, 0, 0);
    push_ramp(0, W * H, 1, 9);
    drain(100, 100, -100, 5000, cyc, low);
    check("midreset_new_frame", frame_count, 1);
    check("midreset_samples", n_out, W * H);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
